lcd_text_writer: RTL and testbench



---
 rtl/lcd_text_writer.sv | 159 +++++++++++++++
 tb/tb_lcd_text_writer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// Streams a 32-character text buffer to a 16x2 character LCD slave as Avalon-MM writes.
// Optional LCD_WRITER_AUTO_REFRESH_EN: any buffer write schedules a refresh by itself.
module lcd_text_writer (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_we,
    input  logic [4:0] char_addr,
    input  logic [7:0] char_data,
    input  logic       update,
    output logic       busy,
    output logic       done,
    output logic       address,
    output logic       chipselect,
    output logic       write,
    output logic       read,
    output logic [7:0] writedata,
    input  logic       waitrequest
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LINE_CMD = 2'd1,
        CHARS    = 2'd2,
        FINISH   = 2'd3
    } state_t;

    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;
    localparam logic [7:0] SPACE     = 8'h20;

    state_t     state;
    logic       ln;
    logic [3:0] cc;
    logic       pending;
    logic       auto_start;
    logic       start;
    logic       accepted;
    logic [7:0] buffer [32];

    // The slave takes a transfer on any edge where we present and it is not stalling.
    assign accepted = chipselect & ~waitrequest;
    assign start    = update | pending | auto_start;
    assign read     = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                buffer[i] <= SPACE;
            end
        end else if (char_we) begin
            buffer[char_addr] <= char_data;
        end
    end

    // Requests arriving while a refresh runs collapse into one follow-up refresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (state == IDLE) begin
            pending <= 1'b0;
        end else if (update) begin
            pending <= 1'b1;
        end
    end

`ifdef LCD_WRITER_AUTO_REFRESH_EN
    logic dirty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty <= 1'b0;
        end else if (char_we) begin
            dirty <= 1'b1;
        end else if (state == IDLE && start) begin
            dirty <= 1'b0;
        end
    end

    assign auto_start = dirty;
`else
    assign auto_start = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ln         <= 1'b0;
            cc         <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            address    <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ln    <= 1'b0;
                        cc    <= 4'd0;
                        state <= LINE_CMD;
                    end
                end

                LINE_CMD: begin
                    // Line 1 enters here idle and loads its command; line 2 arrives already loaded.
                    if (!chipselect) begin
                        busy       <= 1'b1;
                        chipselect <= 1'b1;
                        write      <= 1'b1;
                        address    <= 1'b0;
                        writedata  <= ln ? CMD_LINE2 : CMD_LINE1;
                    end else if (accepted) begin
                        cc        <= 4'd0;
                        address   <= 1'b1;
                        writedata <= buffer[{ln, 4'd0}];
                        state     <= CHARS;
                    end
                end

                CHARS: begin
                    // Characters are sampled when loaded, so stalled writes keep their byte.
                    if (accepted) begin
                        if (cc == 4'd15) begin
                            if (!ln) begin
                                ln        <= 1'b1;
                                cc        <= 4'd0;
                                address   <= 1'b0;
                                writedata <= CMD_LINE2;
                                state     <= LINE_CMD;
                            end else begin
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                chipselect <= 1'b0;
                                write      <= 1'b0;
                                address    <= 1'b0;
                                state      <= FINISH;
                            end
                        end else begin
                            cc        <= cc + 4'd1;
                            writedata <= buffer[{ln, cc + 4'd1}];
                        end
                    end
                end

                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Bench for lcd_text_writer: a buffer model predicts each refresh's 34 transfers into a queue.
// Build with LCD_WRITER_AUTO_REFRESH_EN defined to exercise the auto-refresh variant.
module tb_lcd_text_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       char_we = 1'b0;
    logic [4:0] char_addr = 5'd0;
    logic [7:0] char_data = 8'h00;
    logic       update = 1'b0;
    logic       busy, done, address, chipselect, write, read;
    logic [7:0] writedata;
    logic       waitrequest = 1'b0;

    lcd_text_writer dut (
        .clk(clk), .reset(reset), .char_we(char_we), .char_addr(char_addr),
        .char_data(char_data), .update(update), .busy(busy), .done(done),
        .address(address), .chipselect(chipselect), .write(write), .read(read),
        .writedata(writedata), .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    logic [8:0] exp_q[$];
    logic [7:0] model_buf [32];
    logic [7:0] acc_log [128];
    int acc_cnt = 0;
    int done_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    int stall_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected refresh: line 1 cursor, chars 0-15, line 2 cursor, chars 16-31.
    task automatic push_refresh();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, model_buf[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, model_buf[i]});
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        char_we = 1'b1; char_addr = a; char_data = d;
        model_buf[a] = d;
        @(posedge clk); #1;
        char_we = 1'b0;
    endtask

    task automatic pulse_update();
        @(posedge clk); #1 update = 1'b1;
        @(posedge clk); #1 update = 1'b0;
    endtask

    task automatic wait_done(input int start, input int max, output int lat);
        int cyc;
        bit found;
        cyc = start;
        found = 0;
        while (cyc < max && !found) begin
            @(negedge clk);
            cyc++;
            if (done) found = 1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", max);
        end
        lat = cyc - 1;
    endtask

    // Slave model: stalls each newly presented transfer for stall_n cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (chipselect && write && wcnt < stall_n) begin
                waitrequest = 1'b1;
                wcnt++;
            end else begin
                waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Compare process: every presented transfer must match the head of the expected queue.
    logic       prev_stall = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_addr;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            chk("read_low", read, 1'b0);
            chk("cs_eq_write", chipselect, write);
            if (chipselect) chk("busy_during_xfer", busy, 1'b1);
            if (done) begin
                chk("done_not_busy", {busy, chipselect}, 2'b00);
                chk("done_single_cycle", prev_done, 1'b0);
                done_cnt++;
            end
            if (prev_stall) begin
                chk("stall_hold", {chipselect, write, address, writedata}, {2'b11, prev_addr, prev_data});
            end
            if (chipselect && write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", {address, writedata}, 9'h1FF);
                end else begin
                    chk("xfer", {address, writedata}, exp_q[0]);
                    if (!waitrequest) begin
                        if (acc_cnt < 128) acc_log[acc_cnt] = writedata;
                        acc_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = chipselect & write & waitrequest;
            prev_addr  = address;
            prev_data  = writedata;
            prev_done  = done;
        end
    end

    initial begin
        int lat;
        int d0;
        bit hit;
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, chipselect, write, read, address}, 6'b0);
        chk("reset_writedata", writedata, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        // Blank refresh with no stalls
        acc_cnt = 0;
        push_refresh();
        chk("model_len", exp_q.size(), 34);
        pulse_update();
        @(negedge clk);
        chk("start_gap", {busy, chipselect}, 2'b00);
        @(negedge clk);
        chk("first_xfer", {busy, chipselect, write, address, writedata}, {4'b1110, 8'h80});
        wait_done(2, 100, lat);
        chk("latency_nostall", lat, 35);
        chk("blank_count", acc_cnt, 34);
        chk("blank_byte", acc_log[33], 8'h20);

`ifndef LCD_WRITER_AUTO_REFRESH_EN
        // HELLO / WORLD content
        wr(5'd0, 8'h48); wr(5'd1, 8'h45); wr(5'd2, 8'h4C); wr(5'd3, 8'h4C); wr(5'd4, 8'h4F);
        wr(5'd16, 8'h57); wr(5'd17, 8'h4F); wr(5'd18, 8'h52); wr(5'd19, 8'h4C); wr(5'd20, 8'h44);
        repeat (3) @(posedge clk);
        chk("no_auto_start", busy, 1'b0);
        acc_cnt = 0;
        push_refresh();
        pulse_update();
        wait_done(0, 100, lat);
        chk("hello_0", acc_log[1], 8'h48);
        chk("hello_4", acc_log[5], 8'h4F);
        chk("hello_pad", acc_log[6], 8'h20);
        chk("line2_cmd", acc_log[17], 8'hC0);
        chk("world_0", acc_log[18], 8'h57);
        chk("world_4", acc_log[22], 8'h44);
`endif

        // Three stall cycles per transfer
        stall_n = 3;
        acc_cnt = 0;
        push_refresh();
        pulse_update();
`ifndef LCD_WRITER_AUTO_REFRESH_EN
        // Overwrite index 2 while its transfer is stalled; the in-flight byte must not change.
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            if (acc_cnt == 3) hit = 1;
        end
        chk("reach_xfer3", hit, 1'b1);
        #1;
        char_we = 1'b1; char_addr = 5'd2; char_data = 8'h58;
        @(posedge clk); #1;
        char_we = 1'b0;
        wait_done(0, 200, lat);
        model_buf[2] = 8'h58;
        chk("stall_count", acc_cnt, 34);
        chk("inflight_kept", acc_log[3], 8'h4C);
`else
        wait_done(0, 200, lat);
        chk("latency_stall", lat, 1 + 4 * 34);
        chk("stall_count", acc_cnt, 34);
`endif
        stall_n = 0;
        repeat (3) @(posedge clk);

        // Pulses during a refresh collapse into exactly one more refresh
        acc_cnt = 0;
        d0 = done_cnt;
        push_refresh();
        push_refresh();
        pulse_update();
        repeat (5) @(posedge clk);
        pulse_update();
        repeat (10) @(posedge clk);
        pulse_update();
        wait_done(0, 100, lat);
        wait_done(0, 100, lat);
        repeat (60) @(negedge clk);
        chk("pending_count", acc_cnt, 68);
        chk("pending_dones", done_cnt - d0, 2);
        chk("pending_idle", busy, 1'b0);
`ifndef LCD_WRITER_AUTO_REFRESH_EN
        chk("second_sees_write", acc_log[34 + 3], 8'h58);
`endif

        // Reset during transfer 10 aborts everything
        acc_cnt = 0;
        push_refresh();
        pulse_update();
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk);
            if (acc_cnt == 10) hit = 1;
        end
        chk("reach_xfer10", hit, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("abort_outputs", {chipselect, write, busy}, 3'b000);
        exp_q.delete();
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("abort_quiet", {busy, chipselect}, 2'b00);
        chk("abort_no_more", acc_cnt, 10);
        acc_cnt = 0;
        push_refresh();
        pulse_update();
        wait_done(0, 100, lat);
        chk("latency_after_reset", lat, 35);
        chk("buffer_cleared", acc_log[1], 8'h20);
        chk("pending_cleared", acc_cnt, 34);

        // A single character write with no update
        repeat (3) @(posedge clk);
        acc_cnt = 0;
`ifdef LCD_WRITER_AUTO_REFRESH_EN
        wr(5'd31, 8'h21);
        push_refresh();
        wait_done(0, 100, lat);
        chk("auto_count", acc_cnt, 34);
        chk("auto_last", acc_log[33], 8'h21);
        repeat (40) @(negedge clk);
        chk("auto_once", acc_cnt, 34);
`else
        wr(5'd31, 8'h21);
        repeat (40) @(negedge clk);
        chk("no_auto_xfers", acc_cnt, 0);
        chk("no_auto_busy", busy, 1'b0);
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
